cla_seq_adder: RTL and testbench
================================

Name: cla_seq_adder

Overview:
Multi-cycle wide adder controller. It sequences one shared 8-bit carry-lookahead slice (cla_8) over WIDTH-bit operands, one byte per cycle, starting at the LSB. The carry is registered between slices. Operands come in and the result goes out on valid/ready handshakes. It sits between an operand producer and a result consumer, wherever a full-width CLA would cost too much area.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of 8 and at least 8 (elaboration error otherwise).
NSLICE, WIDTH/8, derived localparam, not overridable; number of 8-bit slices and RUN cycles.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  reset; asynchronous assert, active-low.
in_valid  input  1  operand transfer request.
in_ready  output  1  block can accept operands.
a  input  WIDTH  addend A, sampled on accept.
b  input  WIDTH  addend B, sampled on accept.
cin  input  1  carry-in, sampled on accept.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts result.
sum  output  WIDTH  registered sum.
cout  output  1  registered carry-out of the MSB slice.
busy  output  1  high in RUN or DONE.

Behaviour:
- Clocking and reset: single clock domain; rst_n is asynchronous and active-low, as already decided.
- Reset values: in_ready=1, out_valid=0, busy=0, sum=0, cout=0, slice index=0, carry register=0, state=IDLE.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready, latch a, b and cin, clear the index and sum register, then go to RUN. Otherwise stay in IDLE.
  - RUN: in_ready=0. Each cycle, feed slice[idx] of a and b plus the carry register into cla_8. Write its s to sum[idx*8 +: 8] and its cout to the carry register, then increment idx. In the cycle where idx==NSLICE-1, go to DONE and load cout from the final slice carry.
  - DONE: out_valid=1. sum and cout hold stable while out_valid && !out_ready. On out_ready, go to IDLE.
- Latency: accept at edge T; out_valid is high from edge T+NSLICE.
- Throughput: one result per NSLICE+2 cycles. DONE never accepts new operands; there is always one IDLE cycle between operations.
- in_valid while busy is ignored. Operands are not queued, and the producer must hold them until it sees in_ready.
- Arithmetic: unsigned modulo 2^WIDTH. cout is the carry out of bit WIDTH-1.
- Width boundary: WIDTH=8 gives exactly one RUN cycle.
- Upper sum bytes read as 0 until their slice is written. sum is only defined while out_valid=1.
- Mid-operation reset: an rst_n assertion in RUN or DONE returns the block to IDLE immediately with all reset values. The in-flight result is discarded.
- Handshake rule: out_valid must never drop without out_ready. Values must not change while valid && !ready.

Optional Feature:
CLA_SEQ_OVF_EN.
- Defined: adds output port ovf (1 bit), the two's-complement signed overflow (carry into MSB XOR carry out of MSB). It is registered with cout and reset to 0.
- Undefined: no ovf port and no extra logic; the rest of the behaviour is identical.

Decomposition:
- Shared package cla_pkg holds:
  - the slice-width constant CLA_SLICE_W=8;
  - the state enum typedef cla_seq_state_t {IDLE, RUN, DONE};
  - a helper function returning NSLICE from WIDTH.
- Natural sub-module: the existing cla_8, instantiated once as the shared datapath slice. The controller adds no other sub-modules.
- With CLA_SEQ_OVF_EN, the MSB-1 carry comes from a separate 7-bit ripple inside the controller, not from changes to cla_8.

Test Plan:
1. WIDTH=32: a=0x0000_0001, b=0x0000_0002, cin=0 → after 4 RUN cycles, out_valid=1, sum=0x0000_0003, cout=0.
2. Full carry ripple: a=0xFFFF_FFFF, b=0x0000_0000, cin=1 → sum=0x0000_0000, cout=1. With CLA_SEQ_OVF_EN defined, ovf=0.
3. Backpressure: a=0x1234_5678, b=0x1111_1111, out_ready held low 10 cycles → sum=0x2345_6789 stays stable and out_valid stays high; the next in_valid pulse is not accepted (in_ready=0) until the cycle after out_ready.
4. Mid-operation reset: accept a=0x8000_0000, b=0x8000_0000, assert rst_n=0 in the second RUN cycle → all outputs reach reset values at once; a new operation after release gives correct sum=0x0000_0000, cout=1 (ovf=1 with CLA_SEQ_OVF_EN).
5. Back-to-back: in_valid held high with two operand sets, out_ready=1 → the second accept happens exactly NSLICE+2 cycles after the first; both results are correct.
6. WIDTH=8 build: a=0xC8, b=0x64, cin=0 → out_valid 1 cycle after accept, sum=0x2C, cout=1.

Source files
------------

// File: rtl/cla_pkg.sv
// cla_pkg: shared slice width, controller state encoding and slice-count helper
// for the sequential carry-lookahead adder.
package cla_pkg;
    localparam int CLA_SLICE_W = 8;

    typedef enum logic [1:0] {IDLE, RUN, DONE} cla_seq_state_t;

    function automatic int nslice(input int width);
        return width / CLA_SLICE_W;
    endfunction
endpackage

// File: rtl/cla_8.sv
// cla_8: 8-bit combinational adder slice built from generate/propagate terms.
module cla_8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout
);
    logic [7:0] w_g;
    logic [7:0] w_p;
    logic       w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    always_comb begin
        s   = '0;
        w_c = cin;
        for (int i = 0; i < 8; i++) begin
            s[i] = w_p[i] ^ w_c;
            w_c  = w_g[i] | (w_p[i] & w_c);
        end
        cout = w_c;
    end
endmodule

// File: rtl/cla_seq_adder.sv
// cla_seq_adder: WIDTH-bit adder that reuses one cla_8 slice per cycle, LSB byte first.
// Define CLA_SEQ_OVF_EN to add the registered two's-complement overflow output ovf.
module cla_seq_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef CLA_SEQ_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);
    localparam int NSLICE = nslice(WIDTH);
    localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if ((WIDTH % CLA_SLICE_W) != 0 || WIDTH < CLA_SLICE_W) begin : g_bad_width
        $error("cla_seq_adder: WIDTH must be a positive multiple of 8");
    end

    cla_seq_state_t                          r_state;
    cla_seq_state_t                          w_next;
    logic [NSLICE-1:0][CLA_SLICE_W-1:0]      r_a;
    logic [NSLICE-1:0][CLA_SLICE_W-1:0]      r_b;
    logic [NSLICE-1:0][CLA_SLICE_W-1:0]      r_sum;
    logic [IW-1:0]                           r_idx;
    logic                                    r_carry;
    logic [CLA_SLICE_W-1:0]                  w_a_sl;
    logic [CLA_SLICE_W-1:0]                  w_b_sl;
    logic [CLA_SLICE_W-1:0]                  w_s;
    logic                                    w_co;
    logic                                    w_last;
    logic                                    w_accept;

    assign w_last   = (r_idx == IW'(NSLICE - 1));
    assign w_accept = (r_state == IDLE) && in_valid;
    assign sum      = r_sum;

    always_comb begin
        w_a_sl = '0;
        w_b_sl = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (r_idx == IW'(i)) begin
                w_a_sl = r_a[i];
                w_b_sl = r_b[i];
            end
        end
    end

    cla_8 u_slice (
        .a    (w_a_sl),
        .b    (w_b_sl),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
        busy      = (r_state != IDLE);
        if (w_accept)                          w_next = RUN;
        else if (r_state == RUN && w_last)     w_next = DONE;
        else if (r_state == DONE && out_ready) w_next = IDLE;
    end

`ifdef CLA_SEQ_OVF_EN
    // Carry into the MSB, rippled over the low 7 bits of the current slice.
    logic w_c7;
    always_comb begin
        w_c7 = r_carry;
        for (int i = 0; i < CLA_SLICE_W - 1; i++)
            w_c7 = (w_a_sl[i] & w_b_sl[i]) | ((w_a_sl[i] ^ w_b_sl[i]) & w_c7);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            cout    <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
            ovf     <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
            r_sum   <= '0;
        end else if (r_state == RUN) begin
            for (int i = 0; i < NSLICE; i++)
                if (r_idx == IW'(i)) r_sum[i] <= w_s;
            r_carry <= w_co;
            r_idx   <= r_idx + IW'(1);
            if (w_last) begin
                cout <= w_co;
`ifdef CLA_SEQ_OVF_EN
                ovf  <= w_c7 ^ w_co;
`endif
            end
        end
    end
endmodule

// File: tb/tb_cla_seq_adder.sv
// tb_cla_seq_adder: randomized and directed checks of cla_seq_adder (WIDTH=32 and WIDTH=8)
// against an arithmetic reference model.
module tb_cla_seq_adder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        cin = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        in_ready, out_valid, cout, busy;
    logic [31:0] sum;
    logic        in_valid8 = 1'b0;
    logic        cin8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        in_ready8, out_valid8, cout8, busy8;
    logic [7:0]  sum8;
`ifdef CLA_SEQ_OVF_EN
    logic        ovf, ovf8;
`endif
    int          n_pass = 0;
    int          n_chk = 0;

    always #5 clk = ~clk;

    cla_seq_adder #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout),
`ifdef CLA_SEQ_OVF_EN
        .ovf(ovf),
`endif
        .busy(busy)
    );

    cla_seq_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(1'b1),
        .sum(sum8), .cout(cout8),
`ifdef CLA_SEQ_OVF_EN
        .ovf(ovf8),
`endif
        .busy(busy8)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic check_result(input string tag, input logic [31:0] ta, input logic [31:0] tb_, input logic tc);
        logic [32:0] r;
        r = {1'b0, ta} + {1'b0, tb_} + 33'(tc);
        chk({tag, "_sum"}, sum, r[31:0]);
        chk({tag, "_cout"}, cout, r[32]);
`ifdef CLA_SEQ_OVF_EN
        chk({tag, "_ovf"}, ovf, (ta[31] == tb_[31]) && (r[31] != ta[31]));
`endif
    endtask

    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_, input logic tc, input int stall);
        int lat;
        @(negedge clk);
        a = ta; b = tb_; cin = tc; in_valid = 1'b1; out_ready = (stall == 0);
        for (int k = 0; k < 40 && !in_ready; k++) @(negedge clk);
        chk("in_ready_pre", in_ready, 1);
        @(posedge clk); #1 in_valid = 1'b0;
        chk("run_flags", {busy, in_ready, out_valid}, 3'b100);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, 4);
        check_result("res", ta, tb_, tc);
        for (int k = 0; k < stall; k++) begin
            in_valid = 1'b1; a = ~ta; b = ~tb_;
            @(posedge clk); #1;
            chk("stall_flags", {out_valid, in_ready, busy}, 3'b101);
            check_result("stall", ta, tb_, tc);
        end
        out_ready = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        chk("release", {out_valid, in_ready, busy}, 3'b010);
        if (stall > 0) begin
            @(posedge clk); #1;
            chk("no_accept", {in_ready, busy}, 2'b10);
        end
    endtask

    task automatic op8(input logic [7:0] ta, input logic [7:0] tb_, input logic tc);
        logic [8:0] r;
        r = {1'b0, ta} + {1'b0, tb_} + 9'(tc);
        @(negedge clk);
        a8 = ta; b8 = tb_; cin8 = tc; in_valid8 = 1'b1;
        chk("w8_ready", in_ready8, 1);
        @(posedge clk); #1 in_valid8 = 1'b0;
        chk("w8_busy", {busy8, out_valid8}, 2'b10);
        @(posedge clk); #1;
        chk("w8_valid", out_valid8, 1);
        chk("w8_sum", sum8, r[7:0]);
        chk("w8_cout", cout8, r[8]);
`ifdef CLA_SEQ_OVF_EN
        chk("w8_ovf", ovf8, (ta[7] == tb_[7]) && (r[7] != ta[7]));
`endif
        @(posedge clk); #1;
        chk("w8_idle", {out_valid8, in_ready8}, 2'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] x1, y1, x2, y2;
        longint      t1, t2;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_flags", {in_ready, out_valid, busy, cout}, 4'b1000);
        chk("rst_sum", sum, 0);
        @(negedge clk) rst_n = 1'b1;

        do_op(32'h0000_0001, 32'h0000_0002, 1'b0, 0);
        do_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0);

        // Abort an operation mid-flight; cout still holds 1 from the previous result.
        @(negedge clk);
        a = 32'h8000_0000; b = 32'h8000_0000; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk("midrst_flags", {in_ready, out_valid, busy, cout}, 4'b1000);
        chk("midrst_sum", sum, 0);
`ifdef CLA_SEQ_OVF_EN
        chk("midrst_ovf", ovf, 0);
`endif
        @(negedge clk) rst_n = 1'b1;
        do_op(32'h8000_0000, 32'h8000_0000, 1'b0, 0);

        do_op(32'h1234_5678, 32'h1111_1111, 1'b0, 10);

        x1 = $urandom; y1 = $urandom; x2 = $urandom; y2 = $urandom;
        @(negedge clk);
        a = x1; b = y1; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); t1 = longint'($time);
        #1 a = x2; b = y2; cin = 1'b1;
        for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
        check_result("b2b1", x1, y1, 1'b0);
        for (int k = 0; k < 20 && !in_ready; k++) @(negedge clk);
        @(posedge clk); t2 = longint'($time);
        #1 in_valid = 1'b0;
        chk("b2b_gap", (t2 - t1) / 10, 6);
        for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
        check_result("b2b2", x2, y2, 1'b1);
        @(posedge clk); #1;

        op8(8'hC8, 8'h64, 1'b0);
        op8(8'hFF, 8'h00, 1'b1);
        for (int k = 0; k < 4; k++)
            op8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));

        for (int k = 0; k < 16; k++)
            do_op($urandom, $urandom, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
